// File: rtl/cuckoo_pkg.sv
// Shared types for the two-table cuckoo hash store: command/status encodings,
// the table entry layout and the controller state encoding.
package cuckoo_pkg;

  // Table geometry; the controller's KEY_W/IDX_W parameters must match these.
  localparam int unsigned ENTRY_KEY_W = 32;
  localparam int unsigned ENTRY_IDX_W = 5;
  localparam int unsigned KICK_W      = 8;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_LOOKUP = 1'b1;

  typedef enum logic [1:0] {
    ST_INSERTED = 2'b00,
    ST_HIT      = 2'b01,
    ST_MISS     = 2'b10,
    ST_FAIL     = 2'b11
  } status_e;

  // alt holds the slot index this key would occupy in the other table.
  typedef struct packed {
    logic                   valid;
    logic [ENTRY_KEY_W-1:0] key;
    logic [ENTRY_IDX_W-1:0] alt;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_KICK_T1,
    S_KICK_T2,
    S_RESP
  } state_e;

endpackage

// File: rtl/cuckoo_table.sv
// One cuckoo table: 2**ENTRY_IDX_W entries, combinational read, synchronous write.
// Ports: clk, rst_n (clears valid bits only), rd_idx -> rd_entry_c,
//        wr_en/wr_idx/wr_entry write port.
module cuckoo_table
  import cuckoo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ENTRY_IDX_W-1:0] rd_idx,
  output entry_t                 rd_entry_c,
  input  logic                   wr_en,
  input  logic [ENTRY_IDX_W-1:0] wr_idx,
  input  entry_t                 wr_entry
);

  localparam int unsigned DEPTH = 2 ** ENTRY_IDX_W;

  logic [DEPTH-1:0]       valid_q;
  logic [ENTRY_KEY_W-1:0] key_q [DEPTH];
  logic [ENTRY_IDX_W-1:0] alt_q [DEPTH];

  // Valid bits are the only reset state; payload is don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_q[wr_idx] <= wr_entry.key;
      alt_q[wr_idx] <= wr_entry.alt;
    end
  end

  // Read port.
  always_comb begin
    rd_entry_c.valid = valid_q[rd_idx];
    rd_entry_c.key   = key_q[rd_idx];
    rd_entry_c.alt   = alt_q[rd_idx];
  end

endmodule

// File: rtl/cuckoo_insert_ctrl.sv
// Cuckoo hash insert/lookup controller owning both tables and running the
// bounded displacement chain that alternates between table 1 and table 2.
// Ports: req_* command handshake (op, key, idx1, idx2); rsp_* response
// handshake (status, key, kicks), held until rsp_ready; occupancy = valid
// entries across both tables.
module cuckoo_insert_ctrl
  import cuckoo_pkg::*;
#(
  parameter int unsigned KEY_W     = ENTRY_KEY_W,
  parameter int unsigned IDX_W     = ENTRY_IDX_W,
  parameter int unsigned MAX_KICKS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [KEY_W-1:0] req_key,
  input  logic [IDX_W-1:0] req_idx1,
  input  logic [IDX_W-1:0] req_idx2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [KEY_W-1:0] rsp_key,
  output logic [7:0]       rsp_kicks,
  output logic [IDX_W+1:0] occupancy
);

  localparam int unsigned OCC_W = IDX_W + 2;
  localparam logic [KICK_W-1:0] KICK_LIMIT = KICK_W'(MAX_KICKS);

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [IDX_W-1:0]    idx1_q, idx1_d;
  logic [IDX_W-1:0]    idx2_q, idx2_d;
  logic [KEY_W-1:0]    ck_q, ck_d;        // carried (evicted) key
  logic [IDX_W-1:0]    calt_q, calt_d;    // carried key's slot in the target table
  logic [IDX_W-1:0]    cfrom_q, cfrom_d;  // slot it was evicted from (becomes its alt)
  logic [KICK_W-1:0]   kicks_q, kicks_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  status_e             rsp_status_q, rsp_status_d;
  logic [KEY_W-1:0]    rsp_key_q, rsp_key_d;
  logic [KICK_W-1:0]   rsp_kicks_q, rsp_kicks_d;

  logic [IDX_W-1:0]    t1_rd_idx, t2_rd_idx, t1_wr_idx, t2_wr_idx;
  entry_t              t1_rd, t2_rd, t1_wr, t2_wr, kick_rd;
  logic                t1_we, t2_we;
  logic                t1_match, t2_match;
  logic                finish;
  status_e             fin_status;
  logic [KEY_W-1:0]    fin_key;

  cuckoo_table u_t1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (t1_rd_idx),
    .rd_entry_c (t1_rd),
    .wr_en      (t1_we),
    .wr_idx     (t1_wr_idx),
    .wr_entry   (t1_wr)
  );

  cuckoo_table u_t2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (t2_rd_idx),
    .rd_entry_c (t2_rd),
    .wr_en      (t2_we),
    .wr_idx     (t2_wr_idx),
    .wr_entry   (t2_wr)
  );

  assign t1_match = t1_rd.valid && (t1_rd.key == key_q);
  assign t2_match = t2_rd.valid && (t2_rd.key == key_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_INSERT;
      key_q        <= '0;
      idx1_q       <= '0;
      idx2_q       <= '0;
      ck_q         <= '0;
      calt_q       <= '0;
      cfrom_q      <= '0;
      kicks_q      <= '0;
      occ_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_INSERTED;
      rsp_key_q    <= '0;
      rsp_kicks_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_q        <= key_d;
      idx1_q       <= idx1_d;
      idx2_q       <= idx2_d;
      ck_q         <= ck_d;
      calt_q       <= calt_d;
      cfrom_q      <= cfrom_d;
      kicks_q      <= kicks_d;
      occ_q        <= occ_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_key_q    <= rsp_key_d;
      rsp_kicks_q  <= rsp_kicks_d;
    end
  end

  // Next-state, table access and response computation.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    idx1_d       = idx1_q;
    idx2_d       = idx2_q;
    ck_d         = ck_q;
    calt_d       = calt_q;
    cfrom_d      = cfrom_q;
    kicks_d      = kicks_q;
    occ_d        = occ_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_key_d    = rsp_key_q;
    rsp_kicks_d  = rsp_kicks_q;

    // Kick states read the carried key's target slot; otherwise the candidates.
    t1_rd_idx = (state_q == S_KICK_T1) ? calt_q : idx1_q;
    t2_rd_idx = (state_q == S_KICK_T2) ? calt_q : idx2_q;
    kick_rd   = (state_q == S_KICK_T1) ? t1_rd : t2_rd;

    t1_we     = 1'b0;
    t2_we     = 1'b0;
    t1_wr_idx = calt_q;
    t2_wr_idx = calt_q;
    t1_wr     = '{valid: 1'b1, key: ck_q, alt: cfrom_q};
    t2_wr     = '{valid: 1'b1, key: ck_q, alt: cfrom_q};

    finish     = 1'b0;
    fin_status = ST_INSERTED;
    fin_key    = key_q;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          op_d        = req_op;
          key_d       = req_key;
          idx1_d      = req_idx1;
          idx2_d      = req_idx2;
          kicks_d     = '0;
          req_ready_d = 1'b0;
          state_d     = S_PROBE;
        end
      end

      S_PROBE: begin
        if (t1_match || t2_match) begin
          finish     = 1'b1;
          fin_status = ST_HIT;
        end else if (op_q == OP_LOOKUP) begin
          finish     = 1'b1;
          fin_status = ST_MISS;
        end else begin
          // New key always lands in T1[idx1]; any resident becomes the carry.
          t1_we     = 1'b1;
          t1_wr_idx = idx1_q;
          t1_wr     = '{valid: 1'b1, key: key_q, alt: idx2_q};
          if (!t1_rd.valid) begin
            occ_d  = occ_q + OCC_W'(1);
            finish = 1'b1;
          end else begin
            ck_d    = t1_rd.key;
            calt_d  = t1_rd.alt;
            cfrom_d = idx1_q;
            kicks_d = KICK_W'(1);
            state_d = S_KICK_T2;
          end
        end
      end

      S_KICK_T1, S_KICK_T2: begin
        if (kick_rd.valid && (kicks_q == KICK_LIMIT)) begin
          // Chain exhausted: drop the carried key, tables untouched.
          finish     = 1'b1;
          fin_status = ST_FAIL;
          fin_key    = ck_q;
        end else begin
          t1_we = (state_q == S_KICK_T1);
          t2_we = (state_q == S_KICK_T2);
          if (!kick_rd.valid) begin
            occ_d  = occ_q + OCC_W'(1);
            finish = 1'b1;
          end else begin
            ck_d    = kick_rd.key;
            calt_d  = kick_rd.alt;
            cfrom_d = calt_q;
            kicks_d = kicks_q + KICK_W'(1);
            state_d = (state_q == S_KICK_T1) ? S_KICK_T2 : S_KICK_T1;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      rsp_valid_d  = 1'b1;
      rsp_status_d = fin_status;
      rsp_key_d    = fin_key;
      rsp_kicks_d  = kicks_q;
      state_d      = S_RESP;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_key    = rsp_key_q;
  assign rsp_kicks  = rsp_kicks_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_cuckoo_insert_ctrl.sv
// Bench for cuckoo_insert_ctrl: two instances (MAX_KICKS 16 and 2) share the
// command inputs; sel routes req_valid and picks which outputs are observed.
// Expected results come from a key/home-pair model of both tables.
module tb_cuckoo_insert_ctrl;

  localparam int unsigned NS  = 32;
  localparam int          MK0 = 16;
  localparam int          MK1 = 2;

  localparam logic [31:0] KA1   = 32'hAAAA0001;
  localparam logic [31:0] KB2   = 32'hBBBB0002;
  localparam logic [31:0] KCA   = 32'hC0DE0001;
  localparam logic [31:0] KCB   = 32'hC0DE0002;
  localparam logic [31:0] KCC   = 32'hC0DE0003;
  localparam logic [31:0] KSTR  = 32'h5555AAAA;
  localparam logic [31:0] KP    = 32'h0000_1010;
  localparam logic [31:0] KQ    = 32'h0000_2020;
  localparam logic [31:0] KR    = 32'h0000_3030;
  localparam logic [31:0] KN    = 32'h0000_4040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_op, rsp_ready;
  logic [31:0] req_key;
  logic [4:0]  req_idx1, req_idx2;
  bit          sel;

  logic        rv0, rv1, rr0, rr1, sv0, sv1;
  logic [1:0]  st0, st1;
  logic [31:0] k0, k1;
  logic [7:0]  kc0, kc1;
  logic [6:0]  oc0, oc1;

  logic        cur_rr, cur_sv;
  logic [1:0]  cur_st;
  logic [31:0] cur_key;
  logic [7:0]  cur_kc;
  logic [6:0]  cur_occ;

  always #5 clk = ~clk;

  assign rv0     = req_valid && !sel;
  assign rv1     = req_valid && sel;
  assign cur_rr  = sel ? rr1 : rr0;
  assign cur_sv  = sel ? sv1 : sv0;
  assign cur_st  = sel ? st1 : st0;
  assign cur_key = sel ? k1 : k0;
  assign cur_kc  = sel ? kc1 : kc0;
  assign cur_occ = sel ? oc1 : oc0;

  cuckoo_insert_ctrl #(.KEY_W(32), .IDX_W(5), .MAX_KICKS(MK0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_op(req_op),
    .req_key(req_key), .req_idx1(req_idx1), .req_idx2(req_idx2), .rsp_valid(sv0),
    .rsp_ready(rsp_ready), .rsp_status(st0), .rsp_key(k0), .rsp_kicks(kc0), .occupancy(oc0)
  );

  cuckoo_insert_ctrl #(.KEY_W(32), .IDX_W(5), .MAX_KICKS(MK1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_op(req_op),
    .req_key(req_key), .req_idx1(req_idx1), .req_idx2(req_idx2), .rsp_valid(sv1),
    .rsp_ready(rsp_ready), .rsp_status(st1), .rsp_key(k1), .rsp_kicks(kc1), .occupancy(oc1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: per instance, per table, per slot -> resident key and its two homes.
  bit          mv  [2][2][NS];
  logic [31:0] mk  [2][2][NS];
  logic [4:0]  mh1 [2][2][NS];
  logic [4:0]  mh2 [2][2][NS];
  int          mocc [2];

  logic [1:0]  last_st;
  logic [31:0] last_key;
  logic [7:0]  last_kc;
  int          last_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mocc[s] = 0;
      for (int t = 0; t < 2; t++)
        for (int i = 0; i < NS; i++) mv[s][t][i] = 1'b0;
    end
  endtask

  // Cuckoo rules: key tries T1 at home1; a displaced key moves to its other home.
  task automatic model_cmd(input bit s, input logic op, input logic [31:0] key,
                           input logic [4:0] i1, input logic [4:0] i2,
                           output logic [1:0] est, output logic [31:0] ekey, output int ekicks);
    int          lim;
    bit          t;
    logic [4:0]  slot, c1, c2, o1, o2;
    logic [31:0] ck, okey;
    lim    = s ? MK1 : MK0;
    ekey   = key;
    ekicks = 0;
    est    = 2'b00;
    if ((mv[s][0][i1] && mk[s][0][i1] == key) || (mv[s][1][i2] && mk[s][1][i2] == key)) begin
      est = 2'b01;
    end else if (op) begin
      est = 2'b10;
    end else begin
      ck = key; c1 = i1; c2 = i2; t = 1'b0;
      for (int step = 0; step <= lim + 1; step++) begin
        slot = t ? c2 : c1;
        if (!mv[s][t][slot]) begin
          mv[s][t][slot] = 1'b1; mk[s][t][slot] = ck;
          mh1[s][t][slot] = c1; mh2[s][t][slot] = c2;
          mocc[s]++;
          est = 2'b00;
          break;
        end
        if (ekicks == lim) begin
          est  = 2'b11;
          ekey = ck;
          break;
        end
        okey = mk[s][t][slot]; o1 = mh1[s][t][slot]; o2 = mh2[s][t][slot];
        mk[s][t][slot] = ck; mh1[s][t][slot] = c1; mh2[s][t][slot] = c2;
        ck = okey; c1 = o1; c2 = o2;
        ekicks++;
        t = !t;
      end
    end
  endtask

  task automatic send(input logic op, input logic [31:0] key, input logic [4:0] i1, input logic [4:0] i2);
    int w;
    w = 0;
    @(negedge clk);
    while (!cur_rr && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 64'(cur_rr), 64'd1);
    req_op = op; req_key = key; req_idx1 = i1; req_idx2 = i2; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("req_ready_busy", 64'(cur_rr), 64'd0);
    end while (!cur_sv && lat < 60);
    chk("rsp_valid_timeout", 64'(cur_sv), 64'd1);
  endtask

  task automatic run(input string tag, input logic op, input logic [31:0] key,
                     input logic [4:0] i1, input logic [4:0] i2);
    logic [1:0]  est;
    logic [31:0] ekey;
    int          ek, lat;
    model_cmd(sel, op, key, i1, i2, est, ekey, ek);
    send(op, key, i1, i2);
    wait_rsp(lat);
    last_st = cur_st; last_key = cur_key; last_kc = cur_kc; last_lat = lat;
    chk({tag, ".status"}, 64'(cur_st), 64'(est));
    chk({tag, ".key"}, 64'(cur_key), 64'(ekey));
    chk({tag, ".kicks"}, 64'(cur_kc), 64'(ek));
    chk({tag, ".latency"}, 64'(lat), 64'(2 + ek));
    chk({tag, ".occupancy"}, 64'(cur_occ), 64'(mocc[sel]));
    @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 64'(cur_rr), 64'd0);
    chk("rst.rsp_valid", 64'(cur_sv), 64'd0);
    chk("rst.occupancy", 64'(cur_occ), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.req_ready_after", 64'(cur_rr), 64'd1);
  endtask

  task automatic build_chain();
    run("chain.q", 1'b0, KQ, 5'd12, 5'd11);
    run("chain.r", 1'b0, KR, 5'd12, 5'd13);
    run("chain.p", 1'b0, KP, 5'd10, 5'd11);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  est, hold_st;
    logic [31:0] ekey, hold_key;
    logic [7:0]  hold_kc;
    int          ek, lat;
    logic [31:0] pk [12];
    logic [4:0]  p1 [12];
    logic [4:0]  p2 [12];

    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_key = '0;
    req_idx1 = '0; req_idx2 = '0; rsp_ready = 1'b1; sel = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("por.req_ready", 64'(cur_rr), 64'd0);
    chk("por.rsp_valid", 64'(cur_sv), 64'd0);
    chk("por.status", 64'(cur_st), 64'd0);
    chk("por.key", 64'(cur_key), 64'd0);
    chk("por.kicks", 64'(cur_kc), 64'd0);
    chk("por.occupancy", 64'(cur_occ), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("por.req_ready_after", 64'(cur_rr), 64'd1);

    // Basic insert / lookup / duplicate / miss on the 16-kick instance.
    sel = 1'b0;
    run("a1.ins", 1'b0, KA1, 5'd3, 5'd7);
    chk("a1.ins.st_const", 64'(last_st), 64'd0);
    chk("a1.ins.lat_const", 64'(last_lat), 64'd2);
    chk("a1.ins.occ_const", 64'(cur_occ), 64'd1);
    run("a1.look", 1'b1, KA1, 5'd3, 5'd7);
    chk("a1.look.st_const", 64'(last_st), 64'd1);
    run("a1.dup", 1'b0, KA1, 5'd3, 5'd7);
    chk("a1.dup.occ_const", 64'(cur_occ), 64'd1);
    run("b2.miss", 1'b1, KB2, 5'd3, 5'd9);
    chk("b2.miss.st_const", 64'(last_st), 64'd2);
    run("b2.ins", 1'b0, KB2, 5'd3, 5'd9);
    chk("b2.ins.kicks_const", 64'(last_kc), 64'd1);
    chk("b2.ins.lat_const", 64'(last_lat), 64'd3);
    run("a1.look2", 1'b1, KA1, 5'd3, 5'd7);
    run("b2.look", 1'b1, KB2, 5'd3, 5'd9);

    // Conflicting cycle on the 2-kick instance.
    sel = 1'b1;
    run("c.ins_a", 1'b0, KCA, 5'd0, 5'd0);
    run("c.ins_b", 1'b0, KCB, 5'd0, 5'd0);
    chk("c.ins_b.kicks_const", 64'(last_kc), 64'd1);
    chk("c.ins_b.occ_const", 64'(cur_occ), 64'd2);
    run("c.ins_c", 1'b0, KCC, 5'd0, 5'd0);
    chk("c.fail.st_const", 64'(last_st), 64'd3);
    chk("c.fail.key_const", 64'(last_key), 64'(KCA));
    chk("c.fail.kicks_const", 64'(last_kc), 64'd2);
    chk("c.fail.lat_const", 64'(last_lat), 64'd4);
    chk("c.fail.occ_const", 64'(cur_occ), 64'd2);
    run("c.look_b", 1'b1, KCB, 5'd0, 5'd0);
    run("c.look_c", 1'b1, KCC, 5'd0, 5'd0);
    run("c.look_a", 1'b1, KCA, 5'd0, 5'd0);
    chk("c.look_a.st_const", 64'(last_st), 64'd2);

    // Response stall with a competing request held on req_valid.
    sel = 1'b0;
    rsp_ready = 1'b0;
    model_cmd(sel, 1'b1, KA1, 5'd3, 5'd7, est, ekey, ek);
    send(1'b1, KA1, 5'd3, 5'd7);
    wait_rsp(lat);
    hold_st = cur_st; hold_key = cur_key; hold_kc = cur_kc;
    chk("stall.status", 64'(hold_st), 64'(est));
    for (int c = 0; c < 5; c++) begin
      req_op = 1'b0; req_key = KSTR; req_idx1 = 5'd20; req_idx2 = 5'd21; req_valid = 1'b1;
      @(negedge clk);
      chk("stall.rsp_valid", 64'(cur_sv), 64'd1);
      chk("stall.status_hold", 64'(cur_st), 64'(hold_st));
      chk("stall.key_hold", 64'(cur_key), 64'(hold_key));
      chk("stall.kicks_hold", 64'(cur_kc), 64'(hold_kc));
      chk("stall.req_ready", 64'(cur_rr), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall.released", 64'(cur_sv), 64'd0);
    chk("stall.ready_back", 64'(cur_rr), 64'd1);
    run("stall.stray_miss", 1'b1, KSTR, 5'd20, 5'd21);

    // Randomised traffic over a small key pool with crowded home slots.
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      for (int j = 0; j < 12; j++) begin
        pk[j] = $urandom;
        p1[j] = 5'($urandom_range(0, 3));
        p2[j] = 5'($urandom_range(0, 3));
      end
      for (int n = 0; n < 50; n++) begin
        int j;
        j = $urandom_range(0, 11);
        run("rand", ($urandom_range(0, 2) == 0), pk[j], p1[j], p2[j]);
      end
    end

    // Three-kick chain run to completion.
    sel = 1'b0;
    apply_reset();
    build_chain();
    run("chain.n", 1'b0, KN, 5'd10, 5'd20);
    chk("chain.kicks_const", 64'(last_kc), 64'd3);
    chk("chain.lat_const", 64'(last_lat), 64'd5);
    run("chain.look_r", 1'b1, KR, 5'd12, 5'd13);

    // Same chain, reset asserted while kicking.
    apply_reset();
    build_chain();
    send(1'b0, KN, 5'd10, 5'd20);
    repeat (3) begin
      @(negedge clk);
      chk("abort.no_rsp_before", 64'(cur_sv), 64'd0);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort.occupancy", 64'(cur_occ), 64'd0);
    chk("abort.rsp_valid", 64'(cur_sv), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort.no_rsp_after", 64'(cur_sv), 64'd0);
    end
    run("abort.look_p", 1'b1, KP, 5'd10, 5'd11);
    run("abort.look_q", 1'b1, KQ, 5'd12, 5'd11);
    run("abort.look_r", 1'b1, KR, 5'd12, 5'd13);
    run("abort.look_n", 1'b1, KN, 5'd10, 5'd20);
    run("abort.look_a1", 1'b1, KA1, 5'd3, 5'd7);
    chk("abort.look_a1.st_const", 64'(last_st), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cuckoo_insert_ctrl.md
# cuckoo_insert_ctrl

Sequencing controller for the two-table cuckoo hash store. Accepts insert and lookup commands carrying a key and its two candidate indices, and owns both tables. For inserts it runs the bounded displacement (kick) chain, alternating between table 1 and table 2. It reports completion, hit/miss, or failure with the key that was dropped.

## Interface
- KEY_W, 32, key width
- IDX_W, 5, index width; each table holds 2**IDX_W entries
- MAX_KICKS, 16, maximum evictions per insert before failure
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  command valid
- req_ready  output  1  controller can accept a command
- req_op  input  1  0 = insert, 1 = lookup
- req_key  input  KEY_W  key
- req_idx1  input  IDX_W  candidate slot in table 1
- req_idx2  input  IDX_W  candidate slot in table 2
- rsp_valid  output  1  response valid, held until taken
- rsp_ready  input  1  consumer accepts response
- rsp_status  output  2  00 inserted, 01 hit/duplicate, 10 miss, 11 fail
- rsp_key  output  KEY_W  on fail: dropped key; otherwise the request key
- rsp_kicks  output  8  evictions performed by this insert
- occupancy  output  IDX_W+2  number of valid entries across both tables

## Operation
- Each table entry holds {valid, key, alt}.
  - A table-1 entry stores its idx2 as alt.
  - A table-2 entry stores its idx1 as alt.
- States: IDLE, PROBE, KICK_T1, KICK_T2, RESP.
- IDLE: req_ready=1. On req_valid, latch op/key/idx1/idx2, set kicks=0 and go to PROBE.
- PROBE: compare the key against T1[idx1] and T2[idx2]; an entry matches only if it is valid.
  - Lookup: status 01 if either slot matches, else 10 → RESP.
  - Insert, match: status 01 (duplicate), no write → RESP.
  - Insert, T1[idx1] empty: write {1,key,idx2} → status 00 → RESP; occupancy+1.
  - Insert, T1[idx1] occupied: write new entry there and carry the evicted {key,alt}; kicks=1 → KICK_T2 with target index = carried alt.
- KICK_Tn (carry {ck, calt}, target slot s = calt):
  - Slot empty: write the carried entry → status 00 → RESP; occupancy+1.
  - Slot occupied and kicks < MAX_KICKS: swap, carry the new evictee, kicks+1 → other KICK state.
  - Slot occupied and kicks == MAX_KICKS: do not write; status 11; rsp_key = ck → RESP; occupancy unchanged.
  - When an entry is written into table n, its alt field is set to the index it would occupy in the other table.
- RESP: rsp_valid=1; hold all rsp_* stable until rsp_ready, then go to IDLE.
- PROBE compares only the two candidate slots; keys resident elsewhere are not detected.

## Timing
- Reset values: state IDLE, all valid bits 0, req_ready 0 during reset then 1 after release, rsp_valid 0, rsp_status 00, rsp_key 0, rsp_kicks 0, occupancy 0.
- Command accepted at edge T, meaning req_valid and req_ready are both high at that edge.
- Lookup or no-collision insert: rsp_valid rises at T+2.
- Insert with k evictions: rsp_valid at T+2+k.
- Worst-case fail: rsp_valid at T+2+MAX_KICKS.
- req_ready=0 from T+1 until the cycle after rsp_valid&&rsp_ready. One command in flight at a time; no pipelining.
- Table writes occur on the clock edge that leaves PROBE or KICK_*. A lookup issued after an insert response sees that insert.
- rst_n asserted mid-chain: immediate abort, tables invalidated, no response emitted.
- rsp_ready low: the FSM stalls in RESP indefinitely with outputs stable.

## Structure
- Package cuckoo_pkg:
  - op encodings (OP_INSERT, OP_LOOKUP)
  - status encodings (ST_INSERTED, ST_HIT, ST_MISS, ST_FAIL)
  - entry struct {valid, key, alt}
  - FSM state enum
- Sub-module cuckoo_table, instantiated twice:
  - 2**IDX_W entries, one combinational read port, one synchronous write port
  - per-entry valid cleared by rst_n
- The FSM, carry registers, kick counter and occupancy counter live in cuckoo_insert_ctrl.

## Test plan
- Insert key 0xAAAA0001 (idx1=3, idx2=7) into empty tables → status 00, kicks 0, rsp_valid at T+2, occupancy 1; then lookup → status 01.
- Insert the same key again → status 01, occupancy stays 1; lookup of 0xBBBB0002 (idx1=3, idx2=9) → status 10.
- Insert A (3,7), then B (3,9) → B in T1[3], A moves to T2[7], kicks 1, rsp_valid at T+3; lookups of both A and B hit.
- With MAX_KICKS=2, fill a conflicting cycle:
  - Insert A (0,0), then B (0,0) → B in T1[0], A moves to T2[0], kicks 1, status 00, occupancy 2.
  - Insert C (0,0) → C written to T1[0]; B displaced into T2[0]; A displaced and hits the limit → status 11, rsp_key = A, kicks 2, occupancy 2.
  - Lookups of B and C hit; lookup of A misses.
- Hold rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0 throughout; a new req_valid is not accepted.
- Assert rst_n low in the middle of a 3-kick chain → no rsp_valid, occupancy 0, all earlier keys miss after release.
